vip_apb3_master_bridge: RTL and testbench

// Upstream stage of the APB3 agent interface. Converts a valid/ready command

---
 rtl/vip_apb3_master_bridge.sv | 178 +++++++++++++++++
 tb/tb_vip_apb3_master_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_apb3_master_bridge.sv
// vip_apb3_master_bridge
// Turns a valid/ready command stream into single outstanding APB3 transfers
// on a multi-slave bus. The slave is picked by the upper address bits.
// Results, decode errors and slave timeouts come back on a valid/ready
// response stream.
//
// state  | meaning
// IDLE   | cmd_ready=1, waiting for a command
// SETUP  | psel[idx]=1, penable=0, address/data on the bus
// ACCESS | psel[idx]=1, penable=1, waiting for pready[idx] or timeout
// RESP   | rsp_valid=1, result held until rsp_ready

module vip_apb3_master_bridge #(
  parameter int APB_ADDR_WIDTH_P   = 16,
  parameter int APB_DATA_WIDTH_P   = 32,
  parameter int APB_NR_OF_SLAVES_P = 4,
  parameter int SLAVE_SEL_LSB_P    = 12,
  parameter int TIMEOUT_P          = 255
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         cmd_valid,
  output logic                                         cmd_ready,
  input  logic                                         cmd_write,
  input  logic [APB_ADDR_WIDTH_P-1:0]                  cmd_addr,
  input  logic [APB_DATA_WIDTH_P-1:0]                  cmd_wdata,
  output logic                                         rsp_valid,
  input  logic                                         rsp_ready,
  output logic [APB_DATA_WIDTH_P-1:0]                  rsp_rdata,
  output logic                                         rsp_slverr,
  output logic                                         rsp_tmo,
  output logic [APB_ADDR_WIDTH_P-1:0]                  paddr,
  output logic [APB_NR_OF_SLAVES_P-1:0]                psel,
  output logic                                         penable,
  output logic                                         pwrite,
  output logic [APB_DATA_WIDTH_P-1:0]                  pwdata,
  input  logic [APB_NR_OF_SLAVES_P-1:0]                pready,
  input  logic [APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P-1:0] prdata,
  input  logic                                         pslverr
);

  localparam int SEL_W = APB_ADDR_WIDTH_P - SLAVE_SEL_LSB_P;
  localparam int CNT_W = $clog2(TIMEOUT_P + 1);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT_P);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                      state_q,  state_d;
  logic [APB_ADDR_WIDTH_P-1:0] addr_q,   addr_d;
  logic [APB_DATA_WIDTH_P-1:0] wdata_q,  wdata_d;
  logic                        write_q,  write_d;
  logic [APB_DATA_WIDTH_P-1:0] rdata_q,  rdata_d;
  logic                        slverr_q, slverr_d;
  logic                        tmo_q,    tmo_d;
  logic [CNT_W-1:0]            cnt_q,    cnt_d;

  logic [SEL_W-1:0]              cmd_idx;
  logic [SEL_W-1:0]              cur_idx;
  logic                          decode_err;
  logic                          pready_sel;
  logic [APB_DATA_WIDTH_P-1:0]   prdata_sel;
  logic [APB_NR_OF_SLAVES_P-1:0] psel_onehot;

  assign cmd_idx    = cmd_addr[APB_ADDR_WIDTH_P-1:SLAVE_SEL_LSB_P];
  assign cur_idx    = addr_q[APB_ADDR_WIDTH_P-1:SLAVE_SEL_LSB_P];
  // 32-bit compare so that a full 2^SEL_W slave count still decodes correctly
  assign decode_err = 32'(cmd_idx) >= 32'(APB_NR_OF_SLAVES_P);

  // Lane steering for the registered slave index; other lanes are ignored
  always_comb begin
    pready_sel  = 1'b0;
    prdata_sel  = '0;
    psel_onehot = '0;
    for (int i = 0; i < APB_NR_OF_SLAVES_P; i++) begin
      if (cur_idx == SEL_W'(i)) begin
        pready_sel     = pready[i];
        prdata_sel     = prdata[i*APB_DATA_WIDTH_P +: APB_DATA_WIDTH_P];
        psel_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state, capture of the command and of the transfer result
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          write_d  = cmd_write;
          rdata_d  = '0;
          slverr_d = 1'b0;
          tmo_d    = 1'b0;
          cnt_d    = '0;
          if (decode_err) begin
            slverr_d = 1'b1;
            state_d  = RESP;
          end else begin
            state_d  = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_sel) begin
          rdata_d  = write_q ? '0 : prdata_sel;
          slverr_d = pslverr;
          state_d  = RESP;
        end else begin
          // saturate rather than wrap; abort once the budget is used up
          if (cnt_q != TMO_C) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TMO_C) begin
            rdata_d  = '0;
            slverr_d = 1'b1;
            tmo_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset wins in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_slverr = slverr_q;
  assign rsp_tmo    = tmo_q;
  assign paddr      = addr_q;
  assign pwrite     = write_q;
  assign pwdata     = wdata_q;
  // psel/penable derive from state so they drop the cycle after ACCESS ends
  assign psel       = (state_q == SETUP || state_q == ACCESS) ? psel_onehot : '0;
  assign penable    = (state_q == ACCESS);

endmodule

// File: tb/tb_vip_apb3_master_bridge.sv
// Directed bench for vip_apb3_master_bridge with a response scoreboard and
// a small APB slave model (programmable wait states, hang, lane noise).
module tb_vip_apb3_master_bridge;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [15:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_rdata;
  logic         rsp_slverr, rsp_tmo;
  logic [15:0]  paddr;
  logic [3:0]   psel;
  logic         penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pready;
  logic [127:0] prdata;
  logic         pslverr;

  vip_apb3_master_bridge #(
    .APB_ADDR_WIDTH_P(16), .APB_DATA_WIDTH_P(32), .APB_NR_OF_SLAVES_P(4),
    .SLAVE_SEL_LSB_P(12), .TIMEOUT_P(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_tmo(rsp_tmo),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
    int          lat;
    int          pen;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int pen_total = 0;
  int sel_total = 0;
  int acc_cnt = 0;
  int wait_cfg = 0;
  logic hang = 1'b0;
  logic [3:0] noise = 4'h0;
  logic [3:0]  exp_psel = 4'h0;
  logic [15:0] exp_addr = 16'h0;
  logic [31:0] exp_wdata = 32'h0;
  logic        exp_write = 1'b0;

  // slave model: selected lane answers after wait_cfg ACCESS cycles
  assign pready = (hang ? 4'h0 : ((penable && acc_cnt >= wait_cfg) ? psel : 4'h0))
                  | (noise & ~psel);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    acc_cnt <= penable ? acc_cnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // bus monitor: selected lane, stable address/data, penable only with psel
  always @(negedge clk) begin
    if (!rst) begin
      if (penable) pen_total <= pen_total + 1;
      if (psel != 4'h0) begin
        sel_total <= sel_total + 1;
        chk("mon_psel", psel, exp_psel);
        chk("mon_paddr", paddr, exp_addr);
        chk("mon_pwrite", pwrite, exp_write);
        if (exp_write) chk("mon_pwdata", pwdata, exp_wdata);
      end
      if (penable) chk("mon_penable_psel", psel != 4'h0, 1);
    end
  end

  function automatic logic [31:0] lane_val(input int i);
    return prdata[i*32 +: 32];
  endfunction

  int pen0, sel0;

  task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input int wt, input logic hg, input logic se);
    exp_t e;
    int idx;
    idx = int'(a[15:12]);
    if (idx >= 4) begin
      e.rdata = 32'h0; e.slverr = 1'b1; e.tmo = 1'b0; e.lat = 1; e.pen = 0;
    end else if (hg) begin
      e.rdata = 32'h0; e.slverr = 1'b1; e.tmo = 1'b1; e.lat = 2 + TMO; e.pen = TMO;
    end else begin
      e.rdata = w ? 32'h0 : lane_val(idx); e.slverr = se; e.tmo = 1'b0;
      e.lat = 3 + wt; e.pen = wt + 1;
    end
    wait_cfg  = wt;
    hang      = hg;
    pslverr   = se;
    exp_addr  = a;
    exp_wdata = d;
    exp_write = w;
    exp_psel  = (idx < 4) ? 4'(1 << idx) : 4'h0;
    pen0 = pen_total;
    sel0 = sel_total;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
    sb.push_back(e);
    if (idx < 4) begin
      chk("setup_psel", psel, exp_psel);
      chk("setup_penable", penable, 0);
    end else begin
      chk("decode_psel", psel, 0);
    end
  endtask

  task automatic get_rsp(input int hold);
    exp_t e;
    for (int k = 0; k < 60 && !rsp_valid; k++) @(negedge clk);
    if (!rsp_valid) begin
      chk("rsp_wait_expired", rsp_valid, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("rsp_latency", cyc - accept_cyc + 1, e.lat);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_slverr", rsp_slverr, e.slverr);
    chk("rsp_tmo", rsp_tmo, e.tmo);
    chk("penable_cycles", pen_total - pen0, e.pen);
    if (e.pen == 0) chk("psel_cycles", sel_total - sel0, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rdata", rsp_rdata, e.rdata);
      chk("bp_slverr", rsp_slverr, e.slverr);
      chk("bp_tmo", rsp_tmo, e.tmo);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0;
    cmd_wdata = 32'h0; rsp_ready = 1'b0; pslverr = 1'b0;
    prdata = {32'h12345678, 32'h22222222, 32'h11111111, 32'h0BAD0000};
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_slverr", rsp_slverr, 0);
    chk("rst_rsp_tmo", rsp_tmo, 0);
    rst = 1'b0;

    // zero-wait write to slave 1
    send(1'b1, 16'h1004, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    get_rsp(0);

    // read from slave 3 with three wait states
    send(1'b0, 16'h3010, 32'h0, 3, 1'b0, 1'b0);
    get_rsp(0);

    // decode errors: no APB activity
    send(1'b0, 16'h5000, 32'h0, 0, 1'b0, 1'b0);
    get_rsp(0);
    send(1'b1, 16'hF004, 32'h55AA55AA, 0, 1'b0, 1'b0);
    get_rsp(0);

    // timeout with other lanes shouting pready, then a normal transfer
    noise = 4'hF;
    send(1'b0, 16'h0020, 32'h0, 0, 1'b1, 1'b0);
    get_rsp(0);
    send(1'b1, 16'h2040, 32'hCAFEF00D, 1, 1'b0, 1'b0);
    get_rsp(0);
    send(1'b0, 16'h1100, 32'h0, 2, 1'b0, 1'b0);
    get_rsp(0);
    noise = 4'h0;

    // backpressure with pslverr returned
    send(1'b0, 16'h2008, 32'h0, 0, 1'b0, 1'b1);
    get_rsp(5);

    // mixed pattern
    for (int n = 0; n < 6; n++) begin
      int li;
      li = int'($urandom_range(0, 3));
      send(1'($urandom_range(0, 1)), {4'(li), 12'($urandom_range(0, 1023) << 2)},
           $urandom, int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)));
      get_rsp(int'($urandom_range(0, 2)));
    end

    // reset in the middle of ACCESS drops the transfer
    send(1'b0, 16'h1000, 32'h0, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_access_penable", penable, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hang = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    for (int q = 0; q < 4; q++) begin
      chk("post_rst_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    send(1'b0, 16'h3FFC, 32'h0, 1, 1'b0, 1'b0);
    get_rsp(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
